// File: rtl/gpio_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_mmio_ctrl
//  Purpose  : Memory-mapped GPIO with synchronised, debounced inputs, an output
//             register, sticky rising-edge status and a maskable interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module gpio_mmio_ctrl #(
   parameter int IN_WIDTH        = 32,
   parameter int OUT_WIDTH       = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bus_we,
   input  logic                 bus_re,
   input  logic [3:0]           bus_addr,
   input  logic [31:0]          bus_wdata,
   output logic [31:0]          bus_rdata,
   output logic                 bus_ready,
   input  logic [IN_WIDTH-1:0]  pad_in,
   output logic [IN_WIDTH-1:0]  gpio_port_in,
   output logic [OUT_WIDTH-1:0] gpio_port_out,
   output logic                 irq
);

   localparam int                 C_CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_MAX    = C_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]         C_REG_OUT    = 2'd0;
   localparam logic [1:0]         C_REG_IN     = 2'd1;
   localparam logic [1:0]         C_REG_STATUS = 2'd2;
   localparam logic [1:0]         C_REG_EN     = 2'd3;

   logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] r_sync;
   logic [IN_WIDTH-1:0]  w_synced;
   logic [IN_WIDTH-1:0]  r_stable;
   logic [C_CNT_W-1:0]   r_cnt [IN_WIDTH];
   logic [IN_WIDTH-1:0]  w_flip;
   logic [IN_WIDTH-1:0]  w_rise;
   logic [IN_WIDTH-1:0]  r_edge_status;
   logic [IN_WIDTH-1:0]  r_edge_en;
   logic [IN_WIDTH-1:0]  w_clr;
   logic [OUT_WIDTH-1:0] r_out;
   logic [31:0]          r_rdata;
   logic [31:0]          w_rd_mux;
   logic                 r_ready;
   logic                 w_wr;
   logic                 w_rd;
   logic [1:0]           w_sel;
   logic                 w_unused_bits;

   // Address LSBs and write-data bits above the register widths are don't-care.
   assign w_unused_bits = ^{bus_addr[1:0], bus_wdata};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pad_in};
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_flip = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         w_flip[i] = (w_synced[i] != r_stable[i]) && (r_cnt[i] == C_CNT_MAX);
      end
   end

   // A flip towards 1 is exactly a 0->1 transition of the debounced bit.
   assign w_rise = w_flip & w_synced;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stable <= '0;
         for (int i = 0; i < IN_WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_stable <= r_stable ^ w_flip;
         for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_synced[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == C_CNT_MAX) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + C_CNT_W'(1);
            end
         end
      end
   end

   // A simultaneous read is dropped in favour of the write.
   assign w_wr  = bus_we;
   assign w_rd  = bus_re & ~bus_we;
   assign w_sel = bus_addr[3:2];
   assign w_clr = (w_wr && (w_sel == C_REG_STATUS)) ? bus_wdata[IN_WIDTH-1:0] : '0;

   always_comb begin
      w_rd_mux = '0;
      case (w_sel)
         C_REG_OUT:    w_rd_mux = 32'(r_out);
         C_REG_IN:     w_rd_mux = 32'(r_stable);
         C_REG_STATUS: w_rd_mux = 32'(r_edge_status);
         C_REG_EN:     w_rd_mux = 32'(r_edge_en);
         default:      w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out         <= '0;
         r_edge_en     <= '0;
         r_edge_status <= '0;
         r_rdata       <= '0;
         r_ready       <= 1'b0;
      end else begin
         r_ready <= bus_we | bus_re;
         if (w_rd) begin
            r_rdata <= w_rd_mux;
         end
         if (w_wr && (w_sel == C_REG_OUT)) begin
            r_out <= bus_wdata[OUT_WIDTH-1:0];
         end
         if (w_wr && (w_sel == C_REG_EN)) begin
            r_edge_en <= bus_wdata[IN_WIDTH-1:0];
         end
         // New edges take priority over a same-cycle clear.
         r_edge_status <= (r_edge_status & ~w_clr) | w_rise;
      end
   end

   assign bus_rdata     = r_rdata;
   assign bus_ready     = r_ready;
   assign gpio_port_in  = r_stable;
   assign gpio_port_out = r_out;
   assign irq           = |(r_edge_status & r_edge_en);

endmodule
`default_nettype wire
